piso_serializer_ctrl: RTL and testbench
=======================================

// Module: piso_serializer_ctrl
// PURPOSE
//  Sequences a WIDTH-bit parallel-in serial-out shift register. Accepts parallel words on a valid/ready
//  handshake, issues load/shift to the register and drives a framed, MSB-first serial stream.
//  Bits advance only on bit_en, so a rate divider sets the serial speed. Sits between a word source and a serial pin.
// PARAMETERS
//  WIDTH      4   bits per word (>=2)
//  CNT_W      $clog2(WIDTH)   bit-counter width (derived, not overridden)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_data    in   WIDTH  parallel word to serialize
//  in_valid   in   1      in_data valid
//  in_ready   out  1      controller accepts word this cycle (transfer = in_valid & in_ready)
//  bit_en     in   1      serial bit strobe; one bit consumed per cycle with bit_en=1
//  sout       out  1      serial data, MSB first; 0 when not valid
//  sout_valid out  1      sout carries a word bit
//  sout_first out  1      current bit is the word MSB
//  sout_last  out  1      current bit is the word LSB
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, shreg=0, bit_cnt=0; sout=0, sout_valid=0, sout_first=0,
//    sout_last=0, busy=0, in_ready=1 once rst_n released. In-flight word is discarded, no partial resume.
//  - States: IDLE, SHIFT.
//    IDLE: in_ready=1. On transfer: shreg<=in_data, bit_cnt<=0, ->SHIFT.
//    SHIFT: sout=shreg[WIDTH-1], sout_valid=1, sout_first=(bit_cnt==0), sout_last=(bit_cnt==WIDTH-1).
//      bit_en=0: hold shreg and bit_cnt (bit repeats).
//      bit_en=1 & bit_cnt<WIDTH-1: shreg<=shreg<<1 (LSB filled 0), bit_cnt<=bit_cnt+1.
//      bit_en=1 & bit_cnt==WIDTH-1 (last bit consumed): if in_valid: load in_data, bit_cnt<=0, stay SHIFT
//        (back-to-back, no gap bit); else ->IDLE.
//  - in_ready = IDLE | (SHIFT & bit_cnt==WIDTH-1 & bit_en). Combinational from state/bit_cnt/bit_en;
//    it does not depend on in_valid (no combinational loop).
//  - Latency: word accepted at edge N -> its MSB is on sout from cycle after N; WIDTH bit_en strobes
//    consume the word. bit_en in the acceptance cycle from IDLE is ignored.
//  - Outputs sout/sout_first/sout_last/sout_valid are decoded from registers only (glitch-free to pin).
//  - in_data sampled only at transfer; later changes to in_data have no effect on current word.
//  - in_valid while not ready: word is held by the source (standard valid/ready; controller never drops).
//  - bit_cnt never exceeds WIDTH-1; bit_cnt uses CNT_W bits and is compared, not wrapped.
// STRUCTURE
//  - Shared package: state encoding constants (ST_IDLE=0, ST_SHIFT=1).
//  - One sub-module: piso_shreg (WIDTH param; ports clk, rst_n, load, shift, d[WIDTH-1:0], q) -
//    load has priority over shift; q = MSB. Controller holds FSM, bit counter and output decode.
// TESTING
//  1 Reset: rst_n=0 mid-word (bit 2 of 4'b1011) -> all outputs 0 immediately; after release in_ready=1, busy=0.
//  2 Single word 4'b1011, bit_en=1 every cycle -> sout 1,0,1,1 on 4 consecutive cycles, first on bit0,
//    last on bit3, then IDLE, sout_valid=0.
//  3 Back-to-back 4'b1011 then 4'b0110, in_valid held -> 8 contiguous valid bits 1,0,1,1,0,1,1,0;
//    second transfer coincides with first word's last bit; no gap cycle.
//  4 bit_en every 3rd cycle, word 4'b1001 -> each bit held 3 cycles, 12 valid cycles total, shreg unchanged between strobes.
//  5 in_valid=1 while SHIFT with bit_cnt<WIDTH-1 -> in_ready=0, in_data changes ignored, current word intact.
//  6 WIDTH=8, word 8'hA5, bit_en=1 -> sout 1,0,1,0,0,1,0,1; sout_last on 8th bit.

Source files
------------

// File: rtl/piso_serializer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : piso_serializer_ctrl_pkg
// Brief  : Shared state encoding for the PISO serializer controller.
// Rev    : 1.0
// ============================================================================
package piso_serializer_ctrl_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/piso_serializer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : piso_serializer_ctrl_if
// Brief  : Parallel word valid/ready handshake into the serializer.
// Rev    : 1.0
// ============================================================================
interface piso_serializer_ctrl_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/piso_serializer_ctrl_shreg.sv
`default_nettype none
// ============================================================================
// Module : piso_shreg
// Brief  : Parallel-load, left-shift register; load wins over shift, q = MSB.
// Rev    : 1.0
// ============================================================================
module piso_shreg #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic             i_shift,
  input  wire logic [WIDTH-1:0] i_d,
  output logic                  o_q
);

  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_d;
    end else if (i_shift) begin
      r_sh <= {r_sh[WIDTH-2:0], 1'b0};
    end
  end

  assign o_q = r_sh[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/piso_serializer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : piso_serializer_ctrl
// Brief  : FSM, bit counter and framed MSB-first serial decode around piso_shreg.
// Rev    : 1.0
// ============================================================================
module piso_serializer_ctrl
  import piso_serializer_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  piso_serializer_ctrl_if.slave s_in,
  input  wire logic             i_bit_en,
  output logic                  o_sout,
  output logic                  o_sout_valid,
  output logic                  o_sout_first,
  output logic                  o_sout_last,
  output logic                  o_busy
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_last;
  logic             w_adv;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_q;

  assign w_last = (r_bit_cnt == c_LAST);
  assign w_adv  = (r_state == ST_SHIFT) && i_bit_en;

  // Ready is held low while reset is asserted so nothing is offered a transfer.
  assign w_in_ready = rst_n && ((r_state == ST_IDLE) || (w_adv && w_last));
  assign w_xfer     = s_in.valid && w_in_ready;
  assign s_in.ready = w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_adv && w_last && !s_in.valid) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (w_xfer) begin
      r_bit_cnt <= '0;
    end else if (w_adv) begin
      r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_xfer),
    .i_shift (w_adv && !w_last),
    .i_d     (s_in.data),
    .o_q     (w_q)
  );

  always_comb begin
    o_sout       = 1'b0;
    o_sout_valid = 1'b0;
    o_sout_first = 1'b0;
    o_sout_last  = 1'b0;
    o_busy       = 1'b0;
    if (r_state == ST_SHIFT) begin
      o_sout       = w_q;
      o_sout_valid = 1'b1;
      o_sout_first = (r_bit_cnt == '0);
      o_sout_last  = w_last;
      o_busy       = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_piso_serializer_ctrl
// Brief  : Drives WIDTH=4 and WIDTH=8 serializers in lockstep against a word/bit-position model.
// Rev    : 1.0
// ============================================================================
module tb_piso_serializer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_en = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_ctrl_if #(.WIDTH(4)) u_if4 ();
  piso_serializer_ctrl_if #(.WIDTH(8)) u_if8 ();

  logic [1:0] o_sout, o_valid, o_first, o_last, o_busy;

  piso_serializer_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s_in(u_if4), .i_bit_en(bit_en),
    .o_sout(o_sout[0]), .o_sout_valid(o_valid[0]), .o_sout_first(o_first[0]),
    .o_sout_last(o_last[0]), .o_busy(o_busy[0])
  );

  piso_serializer_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .s_in(u_if8), .i_bit_en(bit_en),
    .o_sout(o_sout[1]), .o_sout_valid(o_valid[1]), .o_sout_first(o_first[1]),
    .o_sout_last(o_last[1]), .o_busy(o_busy[1])
  );

  int         n_checks = 0;
  int         n_err    = 0;
  int         mw[2]    = '{4, 8};
  bit         m_active[2];
  int         m_pos[2];
  logic [7:0] m_cur[2];
  logic [15:0] cap[2];
  int         vcnt4;
  logic [1:0] rdy;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_pos[k]    = 0;
      m_cur[k]    = '0;
    end
  endtask

  // One clock cycle: drive at negedge, check #1 later, advance the model at posedge.
  task automatic step(input logic v, input logic [7:0] d, input logic be);
    logic e_sout, e_rdy;
    @(negedge clk);
    u_if4.valid = v; u_if4.data = d[3:0];
    u_if8.valid = v; u_if8.data = d;
    bit_en = be;
    #1;
    rdy = {u_if8.ready, u_if4.ready};
    for (int k = 0; k < 2; k++) begin
      e_sout = m_active[k] ? m_cur[k][mw[k]-1-m_pos[k]] : 1'b0;
      e_rdy  = rst_n && (!m_active[k] || (m_pos[k] == mw[k]-1 && be));
      chk($sformatf("w%0d_sout", mw[k]),  {7'd0, o_sout[k]},  {7'd0, e_sout});
      chk($sformatf("w%0d_valid", mw[k]), {7'd0, o_valid[k]}, {7'd0, m_active[k]});
      chk($sformatf("w%0d_first", mw[k]), {7'd0, o_first[k]}, {7'd0, m_active[k] && m_pos[k] == 0});
      chk($sformatf("w%0d_last", mw[k]),  {7'd0, o_last[k]},  {7'd0, m_active[k] && m_pos[k] == mw[k]-1});
      chk($sformatf("w%0d_busy", mw[k]),  {7'd0, o_busy[k]},  {7'd0, m_active[k]});
      chk($sformatf("w%0d_ready", mw[k]), {7'd0, rdy[k]},     {7'd0, e_rdy});
      if (o_valid[k] && be) cap[k] = {cap[k][14:0], o_sout[k]};
    end
    if (o_valid[0]) vcnt4++;
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (v && rdy[k]) begin
          m_cur[k]    = (k == 0) ? {4'd0, d[3:0]} : d;
          m_pos[k]    = 0;
          m_active[k] = 1'b1;
        end else if (m_active[k] && be) begin
          m_pos[k]++;
          if (m_pos[k] == mw[k]) m_active[k] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    u_if4.valid = 1'b0; u_if4.data = '0;
    u_if8.valid = 1'b0; u_if8.data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // Single word 1011 at full rate
    cap[0] = '0;
    step(1'b1, 8'h0B, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_stream", cap[0][7:0], 8'h0B);
    repeat (6) step(1'b0, 8'h00, 1'b1);

    // Back-to-back 1011 then 0110, second accepted on the first word's last bit
    cap[0] = '0;
    step(1'b1, 8'h0B, 1'b1);
    repeat (4) step(1'b1, 8'h06, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t3_stream", cap[0][7:0], 8'hB6);
    repeat (8) step(1'b0, 8'h00, 1'b1);

    // Strobe every third cycle: 12 valid cycles for one 4-bit word
    cap[0] = '0;
    step(1'b1, 8'h09, 1'b0);
    vcnt4 = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, (i % 3) == 2);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_valid_cycles", 8'(vcnt4), 8'd12);
    chk("t4_stream", cap[0][7:0], 8'h09);
    repeat (10) step(1'b0, 8'h00, 1'b1);

    // Source keeps valid and scrambles data while the word is mid-flight
    cap[0] = '0;
    step(1'b1, 8'h0B, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), 1'b1);
      chk("t5_not_ready", {7'd0, rdy[0]}, 8'd0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("t5_stream", cap[0][7:0], 8'h0B);
    repeat (10) step(1'b0, 8'h00, 1'b1);

    // WIDTH=8 word A5
    cap[1] = '0;
    step(1'b1, 8'hA5, 1'b1);
    repeat (8) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_stream", cap[1][7:0], 8'hA5);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) < 6);
    repeat (10) step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a word (bit 2 of 1011)
    step(1'b1, 8'h0B, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    u_if4.valid = 1'b0; u_if8.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sout",  {6'd0, o_sout},  8'd0);
    chk("rst_valid", {6'd0, o_valid}, 8'd0);
    chk("rst_first", {6'd0, o_first}, 8'd0);
    chk("rst_last",  {6'd0, o_last},  8'd0);
    chk("rst_busy",  {6'd0, o_busy},  8'd0);
    chk("rst_ready", {6'd0, u_if8.ready, u_if4.ready}, 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_ready", {6'd0, rdy}, 8'd3);
    step(1'b1, 8'h0B, 1'b1);
    repeat (9) step(1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
